// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core pipeline control.
package riscv_pkg;

    // Execute-stage operand forwarding selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // ResultSrc encoding that marks a load in Execute
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // Data-memory handshake state
    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one Execute operand; the Memory-stage producer wins over Writeback.
module fwd_unit
    import riscv_pkg::*;
(
    input  logic [4:0] i_RsE,
    input  logic [4:0] i_RdM,
    input  logic [4:0] i_RdW,
    input  logic       i_RegWriteM,
    input  logic       i_RegWriteW,
    output logic [1:0] o_Forward
);

    // Pick the youngest in-flight producer of the source register; x0 never forwards
    always_comb begin
        o_Forward = FWD_RF;
        if (i_RegWriteM && (i_RdM != 5'd0) && (i_RdM == i_RsE)) begin
            o_Forward = FWD_M;
        end else if (i_RegWriteW && (i_RdW != 5'd0) && (i_RdW == i_RsE)) begin
            o_Forward = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use and branch handling, data-memory wait FSM,
// plus a saturating stall-cycle counter and a sticky memory-timeout flag for debug.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned P_TIMEOUT = 64,
    parameter int unsigned P_CNT_W   = 32
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic [4:0]         i_Rs1D,
    input  logic [4:0]         i_Rs2D,
    input  logic [4:0]         i_Rs1E,
    input  logic [4:0]         i_Rs2E,
    input  logic [4:0]         i_RdE,
    input  logic [4:0]         i_RdM,
    input  logic [4:0]         i_RdW,
    input  logic               i_RegWriteM,
    input  logic               i_RegWriteW,
    input  logic [1:0]         i_ResultSrcE,
    input  logic               i_PCSrcE,
    input  logic               i_MemAccessM,
    input  logic               i_DMemReady,
    output logic [1:0]         o_ForwardAE,
    output logic [1:0]         o_ForwardBE,
    output logic               o_StallF,
    output logic               o_StallD,
    output logic               o_StallE,
    output logic               o_StallM,
    output logic               o_FlushD,
    output logic               o_FlushE,
    output logic               o_FlushW,
    output logic               o_DMemReq,
    output logic [P_CNT_W-1:0] o_StallCount,
    output logic               o_MemTimeout
);

    localparam int unsigned WaitW = $clog2(P_TIMEOUT + 1);

    mem_state_t         stateQ, stateD;
    logic [WaitW-1:0]   waitCntQ, waitCntD;
    logic               timeoutQ, timeoutD;
    logic [P_CNT_W-1:0] stallCntQ, stallCntD;
    logic               lwStall;
    logic               memStall;
    logic               memReq;

    fwd_unit u_fwdA (
        .i_RsE       (i_Rs1E),
        .i_RdM       (i_RdM),
        .i_RdW       (i_RdW),
        .i_RegWriteM (i_RegWriteM),
        .i_RegWriteW (i_RegWriteW),
        .o_Forward   (o_ForwardAE)
    );

    fwd_unit u_fwdB (
        .i_RsE       (i_Rs2E),
        .i_RdM       (i_RdM),
        .i_RdW       (i_RdW),
        .i_RegWriteM (i_RegWriteM),
        .i_RegWriteW (i_RegWriteW),
        .o_Forward   (o_ForwardBE)
    );

    // Load in Execute whose destination is read by the instruction in Decode
    always_comb begin
        lwStall = (i_ResultSrcE == RESULT_LOAD) && (i_RdE != 5'd0) &&
                  ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
    end

    // Memory handshake FSM: next state, request and memory stall
    always_comb begin
        stateD   = stateQ;
        memReq   = 1'b0;
        memStall = 1'b0;
        unique case (stateQ)
            MEM_IDLE: begin
                memReq = i_MemAccessM;
                if (i_MemAccessM && !i_DMemReady) begin
                    memStall = 1'b1;
                    stateD   = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                memReq = 1'b1;
                if (i_DMemReady) begin
                    stateD = MEM_IDLE;
                end else begin
                    memStall = 1'b1;
                end
            end
            default: stateD = MEM_IDLE;
        endcase
    end

    // Stall/flush drive; a memory stall overrides load-use and branch flushes, all held low in reset
    always_comb begin
        o_StallF  = i_Reset & (lwStall | memStall);
        o_StallD  = i_Reset & (lwStall | memStall);
        o_StallE  = i_Reset & memStall;
        o_StallM  = i_Reset & memStall;
        o_FlushW  = i_Reset & memStall;
        o_FlushE  = i_Reset & (lwStall | i_PCSrcE) & ~memStall;
        o_FlushD  = i_Reset & i_PCSrcE & ~memStall;
        o_DMemReq = i_Reset & memReq;
    end

    // Wait counter, sticky timeout and saturating stall counter next state
    always_comb begin
        waitCntD  = waitCntQ;
        timeoutD  = timeoutQ;
        stallCntD = stallCntQ;
        if (stateQ == MEM_IDLE) begin
            waitCntD = '0;
        end else if (waitCntQ != WaitW'(P_TIMEOUT)) begin
            waitCntD = waitCntQ + WaitW'(1);
        end
        // The wait cycle that brings the count to P_TIMEOUT raises the flag
        if ((stateQ == MEM_WAIT) && (waitCntQ == WaitW'(P_TIMEOUT - 1))) begin
            timeoutD = 1'b1;
        end
        if (o_StallF && (stallCntQ != '1)) begin
            stallCntD = stallCntQ + P_CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            stateQ    <= MEM_IDLE;
            waitCntQ  <= '0;
            timeoutQ  <= 1'b0;
            stallCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            waitCntQ  <= waitCntD;
            timeoutQ  <= timeoutD;
            stallCntQ <= stallCntD;
        end
    end

    assign o_StallCount = stallCntQ;
    assign o_MemTimeout = timeoutQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;
    import riscv_pkg::*;

    localparam int unsigned TMO = 4;
    localparam int unsigned CW  = 8;

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       regWM, regWW;
        logic [1:0] resSrcE;
        logic       pcSrc, memAcc, ready;
    } vec_t;

    typedef struct {
        string       name;
        logic [20:0] val;
    } exp_t;

    logic          i_Clk = 1'b0;
    logic          i_Reset;
    logic [4:0]    i_Rs1D, i_Rs2D, i_Rs1E, i_Rs2E, i_RdE, i_RdM, i_RdW;
    logic          i_RegWriteM, i_RegWriteW;
    logic [1:0]    i_ResultSrcE;
    logic          i_PCSrcE, i_MemAccessM, i_DMemReady;
    logic [1:0]    o_ForwardAE, o_ForwardBE;
    logic          o_StallF, o_StallD, o_StallE, o_StallM;
    logic          o_FlushD, o_FlushE, o_FlushW, o_DMemReq, o_MemTimeout;
    logic [CW-1:0] o_StallCount;

    vec_t  v;
    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    int    expCnt = 0;

    hazard_ctrl #(
        .P_TIMEOUT (TMO),
        .P_CNT_W   (CW)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Rs1D       (i_Rs1D),
        .i_Rs2D       (i_Rs2D),
        .i_Rs1E       (i_Rs1E),
        .i_Rs2E       (i_Rs2E),
        .i_RdE        (i_RdE),
        .i_RdM        (i_RdM),
        .i_RdW        (i_RdW),
        .i_RegWriteM  (i_RegWriteM),
        .i_RegWriteW  (i_RegWriteW),
        .i_ResultSrcE (i_ResultSrcE),
        .i_PCSrcE     (i_PCSrcE),
        .i_MemAccessM (i_MemAccessM),
        .i_DMemReady  (i_DMemReady),
        .o_ForwardAE  (o_ForwardAE),
        .o_ForwardBE  (o_ForwardBE),
        .o_StallF     (o_StallF),
        .o_StallD     (o_StallD),
        .o_StallE     (o_StallE),
        .o_StallM     (o_StallM),
        .o_FlushD     (o_FlushD),
        .o_FlushE     (o_FlushE),
        .o_FlushW     (o_FlushW),
        .o_DMemReq    (o_DMemReq),
        .o_StallCount (o_StallCount),
        .o_MemTimeout (o_MemTimeout)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic clr();
        v = '{rs1D: 5'd0, rs2D: 5'd0, rs1E: 5'd0, rs2E: 5'd0, rdE: 5'd0, rdM: 5'd0,
              rdW: 5'd0, regWM: 1'b0, regWW: 1'b0, resSrcE: 2'b00, pcSrc: 1'b0,
              memAcc: 1'b0, ready: 1'b0};
    endtask

    // Drive v just after a rising edge and queue the expected outputs for that cycle.
    // st = {F,D,E,M}, fl = {D,E,W}; the stall count comes from a small saturating model.
    task automatic apply(input string name, input logic rst, input logic [1:0] fa,
                         input logic [1:0] fb, input logic [3:0] st, input logic [2:0] fl,
                         input logic req, input logic tmo);
        exp_t e;
        @(posedge i_Clk);
        #1;
        i_Reset      = rst;
        i_Rs1D       = v.rs1D;
        i_Rs2D       = v.rs2D;
        i_Rs1E       = v.rs1E;
        i_Rs2E       = v.rs2E;
        i_RdE        = v.rdE;
        i_RdM        = v.rdM;
        i_RdW        = v.rdW;
        i_RegWriteM  = v.regWM;
        i_RegWriteW  = v.regWW;
        i_ResultSrcE = v.resSrcE;
        i_PCSrcE     = v.pcSrc;
        i_MemAccessM = v.memAcc;
        i_DMemReady  = v.ready;
        if (!rst) expCnt = 0;
        e.name = name;
        e.val  = {fa, fb, st, fl, req, CW'(expCnt), tmo};
        q.push_back(e);
        if (rst && st[3] && (expCnt < 255)) expCnt++;
    endtask

    // Monitor: compare every queued expectation in the middle of its cycle
    always @(negedge i_Clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [20:0] act;
            e   = q.pop_front();
            act = {o_ForwardAE, o_ForwardBE, o_StallF, o_StallD, o_StallE, o_StallM,
                   o_FlushD, o_FlushE, o_FlushW, o_DMemReq, o_StallCount, o_MemTimeout};
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %b_%b_%b_%b_%b_%h_%b expected %b_%b_%b_%b_%b_%h_%b",
                         e.name, act[20:19], act[18:17], act[16:13], act[12:10], act[9],
                         act[8:1], act[0], e.val[20:19], e.val[18:17], e.val[16:13],
                         e.val[12:10], e.val[9], e.val[8:1], e.val[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_Reset = 1'b1;
        clr();
        {i_Rs1D, i_Rs2D, i_Rs1E, i_Rs2E, i_RdE, i_RdM, i_RdW} = '0;
        {i_RegWriteM, i_RegWriteW, i_ResultSrcE, i_PCSrcE, i_MemAccessM, i_DMemReady} = '0;
        #2 i_Reset = 1'b0;

        // In reset: controls low despite hazards, forwarding stays live
        v.memAcc = 1'b1; v.pcSrc = 1'b1; v.regWM = 1'b1; v.rdM = 5'd5; v.rs1E = 5'd5;
        v.resSrcE = RESULT_LOAD; v.rdE = 5'd3; v.rs1D = 5'd3;
        apply("reset_hold", 1'b0, 2'b10, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);
        clr();
        apply("reset_idle", 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Forwarding
        v.regWM = 1'b1; v.rdM = 5'd5; v.regWW = 1'b1; v.rdW = 5'd5; v.rs1E = 5'd5; v.rs2E = 5'd5;
        apply("fwd_m_over_w", 1'b1, 2'b10, 2'b10, 4'b0000, 3'b000, 1'b0, 1'b0);
        v.rdM = 5'd0;
        apply("fwd_w", 1'b1, 2'b01, 2'b01, 4'b0000, 3'b000, 1'b0, 1'b0);
        v.rdW = 5'd0; v.rs1E = 5'd0; v.rs2E = 5'd0;
        apply("fwd_x0", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);
        clr();
        v.regWM = 1'b1; v.rdM = 5'd3; v.rs1E = 5'd3; v.regWW = 1'b1; v.rdW = 5'd4; v.rs2E = 5'd4;
        apply("fwd_a_m_b_w", 1'b1, 2'b10, 2'b01, 4'b0000, 3'b000, 1'b0, 1'b0);
        v.regWM = 1'b0; v.regWW = 1'b0;
        apply("fwd_no_we", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Load-use, one cycle
        clr();
        v.resSrcE = RESULT_LOAD; v.rdE = 5'd7; v.rs2D = 5'd7;
        apply("load_use", 1'b1, 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, 1'b0);
        clr();
        apply("after_load_use", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);
        v.resSrcE = RESULT_LOAD; v.rdE = 5'd0; v.rs1D = 5'd0;
        apply("load_rd_x0", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);
        clr();
        v.resSrcE = 2'b00; v.rdE = 5'd7; v.rs1D = 5'd7;
        apply("non_load_dep", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Branch taken, and branch together with load-use
        clr();
        v.pcSrc = 1'b1;
        apply("branch", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 1'b0);
        v.resSrcE = RESULT_LOAD; v.rdE = 5'd7; v.rs1D = 5'd7;
        apply("load_use_branch", 1'b1, 2'b00, 2'b00, 4'b1100, 3'b110, 1'b0, 1'b0);

        // Memory wait, ready on the 4th request cycle: exactly 3 stall cycles
        clr();
        v.memAcc = 1'b1;
        apply("mem_req_idle", 1'b1, 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b0);
        v.pcSrc = 1'b1; v.resSrcE = RESULT_LOAD; v.rdE = 5'd7; v.rs1D = 5'd7;
        apply("mem_wait_branch", 1'b1, 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b0);
        v.pcSrc = 1'b0; v.resSrcE = 2'b00; v.rdE = 5'd0; v.rs1D = 5'd0;
        apply("mem_wait", 1'b1, 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b0);
        v.ready = 1'b1;
        apply("mem_done", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b0);
        clr();
        apply("mem_back_idle", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Zero-latency access: request but no stall, FSM stays idle
        v.memAcc = 1'b1; v.ready = 1'b1;
        apply("mem_fast", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b0);
        clr();
        apply("mem_fast_idle", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

        // Timeout: flag rises after the 4th MEM_WAIT cycle
        v.memAcc = 1'b1;
        apply("tmo_idle", 1'b1, 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply("tmo_wait_low", 1'b1, 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b0);
        end
        apply("tmo_set", 1'b1, 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b1);

        // Long wait: stall counter saturates at all-ones, timeout stays set
        for (int i = 0; i < 260; i++) begin
            apply("tmo_sticky_sat", 1'b1, 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b1);
        end

        // Reset mid-wait clears everything and drops the request
        apply("reset_mid_wait", 1'b0, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);
        clr();
        apply("post_reset_idle", 1'b1, 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

        @(posedge i_Clk);
        @(negedge i_Clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
